csa_accumulate_sequencer: RTL and testbench



---
 rtl/csa_accumulate_sequencer.sv | 152 +++++++++++++++
 tb/tb_csa_accumulate_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/csa_accumulate_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : csa_accumulate_sequencer
// Description : Sums a variable-length operand stream through a carry-save
//               adder, then does one carry-propagate resolve and holds the
//               result under a valid/ready handshake.
//               Optional macro CSA_SEQ_SIGNED_EN selects signed (sign-extended)
//               operands; default is unsigned (zero-extended).
// Revision    : 1.0 - initial release
// ============================================================================
module csa_accumulate_sequencer #(
    parameter int N     = 8,
    parameter int CNT_W = 4,
    parameter int OUT_W = N + CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_op_count,
    input  logic             i_in_valid,
    input  logic [N-1:0]     i_in_data,
    output logic             o_in_ready,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [OUT_W-1:0] o_result,
    output logic             o_busy
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_ACCUM   = 2'd1;
    localparam logic [1:0] c_RESOLVE = 2'd2;
    localparam logic [1:0] c_OUTPUT  = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_remaining;
    logic [OUT_W-1:0] r_s;
    // Carry bit OUT_W-1 would be shifted out, so only the surviving bits are kept.
    logic [OUT_W-2:0] r_c;
    logic [OUT_W-1:0] r_result;

    logic [OUT_W-1:0] w_x;
    logic [OUT_W-1:0] w_cs;
    logic [OUT_W-1:0] w_s_nxt;
    logic [OUT_W-2:0] w_c_nxt;
    logic             w_accept;
    logic             w_last;

`ifdef CSA_SEQ_SIGNED_EN
    assign w_x = {{(OUT_W-N){i_in_data[N-1]}}, i_in_data};
`else
    assign w_x = {{(OUT_W-N){1'b0}}, i_in_data};
`endif

    assign w_cs     = {r_c, 1'b0};
    assign w_accept = i_in_valid && (r_state == c_ACCUM);
    assign w_last   = w_accept && (r_remaining == CNT_W'(1));

    generate
        for (genvar b = 0; b < OUT_W; b++) begin : g_csa_sum
            assign w_s_nxt[b] = r_s[b] ^ w_cs[b] ^ w_x[b];
        end
        for (genvar b = 0; b < OUT_W - 1; b++) begin : g_csa_carry
            assign w_c_nxt[b] = (r_s[b] & w_cs[b]) | (r_s[b] & w_x[b]) | (w_cs[b] & w_x[b]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (i_start) begin
                    w_state_nxt = (i_op_count == '0) ? c_OUTPUT : c_ACCUM;
                end
            end
            c_ACCUM: begin
                if (w_last) begin
                    w_state_nxt = c_RESOLVE;
                end
            end
            c_RESOLVE: begin
                w_state_nxt = c_OUTPUT;
            end
            c_OUTPUT: begin
                if (i_out_ready) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Handshake outputs decode the state register only; no path from i_in_valid.
    always_comb begin
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        o_busy      = 1'b1;
        case (r_state)
            c_IDLE:   o_busy      = 1'b0;
            c_ACCUM:  o_in_ready  = 1'b1;
            c_OUTPUT: o_out_valid = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_remaining <= '0;
            r_s         <= '0;
            r_c         <= '0;
            r_result    <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (i_start) begin
                        r_remaining <= i_op_count;
                        r_s         <= '0;
                        r_c         <= '0;
                        if (i_op_count == '0) begin
                            r_result <= '0;
                        end
                    end
                end
                c_ACCUM: begin
                    if (w_accept) begin
                        r_s         <= w_s_nxt;
                        r_c         <= w_c_nxt;
                        r_remaining <= r_remaining - CNT_W'(1);
                    end
                end
                c_RESOLVE: begin
                    r_result <= r_s + w_cs;
                end
                default: ;
            endcase
        end
    end

    assign o_result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_csa_accumulate_sequencer.sv
`default_nettype none
// Testbench for csa_accumulate_sequencer: directed scenarios plus random jobs
// checked against an arithmetic sum of the operand queue.
module tb_csa_accumulate_sequencer;

    localparam int N     = 8;
    localparam int CNT_W = 4;
    localparam int OUT_W = N + CNT_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_start;
    logic [CNT_W-1:0] i_op_count;
    logic             i_in_valid;
    logic [N-1:0]     i_in_data;
    logic             o_in_ready;
    logic             o_out_valid;
    logic             i_out_ready;
    logic [OUT_W-1:0] o_result;
    logic             o_busy;

    int n_asserts = 0;
    int n_fail    = 0;
    logic [N-1:0] ops[$];

    csa_accumulate_sequencer #(.N(N), .CNT_W(CNT_W), .OUT_W(OUT_W)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (i_start),
        .i_op_count (i_op_count),
        .i_in_valid (i_in_valid),
        .i_in_data  (i_in_data),
        .o_in_ready (o_in_ready),
        .o_out_valid(o_out_valid),
        .i_out_ready(i_out_ready),
        .o_result   (o_result),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer sum of the extended operands, wrapped to OUT_W bits.
    function automatic logic [OUT_W-1:0] model_sum();
        logic [OUT_W-1:0] acc;
        int v;
        acc = '0;
        foreach (ops[i]) begin
`ifdef CSA_SEQ_SIGNED_EN
            v = int'($signed(ops[i]));
`else
            v = int'(ops[i]);
`endif
            acc = acc + v[OUT_W-1:0];
        end
        return acc;
    endfunction

    // stall_mode: 0 = none, 1 = in_valid every other cycle, 2 = random gaps
    task automatic run_job(input int count, input int stall_mode, input int ready_delay,
                           input bit poke_start);
        logic [OUT_W-1:0] exp;
        logic [OUT_W-1:0] held;
        int idx;
        int cyc;
        bit v;
        exp = model_sum();
        i_start    = 1'b1;
        i_op_count = CNT_W'(count);
        step();
        i_start    = 1'b0;
        i_op_count = CNT_W'($urandom_range(0, 15));
        cyc = 1;
        idx = 0;
        check("busy_after_start", 32'(o_busy), 1);
        while (idx < count && cyc < 400) begin
            check("in_ready_accum", 32'(o_in_ready), 1);
            check("out_valid_accum", 32'(o_out_valid), 0);
            v = (stall_mode == 0) ? 1'b1 :
                (stall_mode == 1) ? cyc[0] : ($urandom_range(0, 99) >= 30);
            i_in_valid = v;
            i_in_data  = v ? ops[idx] : N'($urandom);
            if (poke_start && idx == 1) begin
                i_start    = 1'b1;
                i_op_count = CNT_W'(9);
            end
            step();
            cyc++;
            i_start = 1'b0;
            if (v) idx++;
        end
        i_in_valid = 1'b0;
        while (!o_out_valid && cyc < 400) begin
            step();
            cyc++;
        end
        check("out_valid_seen", 32'(o_out_valid), 1);
        if (stall_mode == 0)
            check("latency", cyc, (count == 0) ? 1 : count + 2);
        check("in_ready_in_output", 32'(o_in_ready), 0);
        check("result", 32'(o_result), 32'(exp));
        held = o_result;
        repeat (ready_delay) begin
            step();
            check("hold_result", 32'(o_result), 32'(held));
            check("hold_busy", 32'(o_busy), 1);
            check("hold_out_valid", 32'(o_out_valid), 1);
        end
        i_out_ready = 1'b1;
        step();
        i_out_ready = 1'b0;
        check("idle_busy", 32'(o_busy), 0);
        check("idle_out_valid", 32'(o_out_valid), 0);
        check("result_kept", 32'(o_result), 32'(exp));
    endtask

    initial begin
        rst_n       = 1'b1;
        i_start     = 1'b0;
        i_op_count  = '0;
        i_in_valid  = 1'b0;
        i_in_data   = '0;
        i_out_ready = 1'b0;
        #1 rst_n = 1'b0;
        step();
        step();
        check("rst_in_ready", 32'(o_in_ready), 0);
        check("rst_out_valid", 32'(o_out_valid), 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_result", 32'(o_result), 0);
        rst_n = 1'b1;
        step();

        // Three operands, no stalls
        ops = '{8'h10, 8'h20, 8'h30};
        run_job(3, 0, 0, 1'b0);
        check("tp_three_ops", 32'(o_result), 32'h060);

        // Fifteen 0xFF operands with alternating in_valid
        ops.delete();
        repeat (15) ops.push_back(8'hFF);
        run_job(15, 1, 1, 1'b0);
`ifdef CSA_SEQ_SIGNED_EN
        check("tp_fifteen_ff", 32'(o_result), 32'hFF1);
`else
        check("tp_fifteen_ff", 32'(o_result), 32'hEF1);
`endif

        // Empty job, consumer stalls for 10 cycles
        ops.delete();
        run_job(0, 0, 10, 1'b0);
        check("tp_empty", 32'(o_result), 0);

        // start pulsed mid-job must be ignored
        ops = '{8'h05, 8'h07, 8'h0B, 8'h0D};
        run_job(4, 0, 0, 1'b1);
        check("tp_start_ignored", 32'(o_result), 32'h024);

        // Reset mid-job after 2 of 4 operands
        i_start    = 1'b1;
        i_op_count = CNT_W'(4);
        step();
        i_start    = 1'b0;
        i_in_valid = 1'b1;
        i_in_data  = 8'h40;
        step();
        i_in_data  = 8'h41;
        step();
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(o_in_ready), 0);
        check("abort_out_valid", 32'(o_out_valid), 0);
        check("abort_busy", 32'(o_busy), 0);
        check("abort_result", 32'(o_result), 0);
        i_in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("post_abort_idle", 32'(o_busy), 0);
        ops = '{8'h01, 8'h02};
        run_job(2, 0, 0, 1'b0);
        check("tp_no_residue", 32'(o_result), 3);

        // Mixed-sign byte pattern
        ops = '{8'h80, 8'h01, 8'hFF};
        run_job(3, 0, 0, 1'b0);
`ifdef CSA_SEQ_SIGNED_EN
        check("tp_signed", 32'(o_result), 32'hF80);
`else
        check("tp_signed", 32'(o_result), 32'h180);
`endif

        // Randomized jobs
        for (int j = 0; j < 12; j++) begin
            int cnt;
            cnt = $urandom_range(0, 15);
            ops.delete();
            for (int k = 0; k < cnt; k++) ops.push_back(N'($urandom));
            run_job(cnt, $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
            repeat ($urandom_range(0, 2)) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
